// File: rtl/controller_emulator_m_if.sv
// controller_emulator_m_if
// Controller connector pins between a host console and the emulated pad.
//   controller_clk    : host shift clock (host -> pad), asynchronous
//   controller_latch  : host latch, active-high (host -> pad), asynchronous
//   controller_data_B : serial button data, low = pressed (pad -> host)
// Modports: master = host side, slave = emulated controller side.
interface controller_emulator_m_if;
  logic controller_clk;
  logic controller_latch;
  logic controller_data_B;

  modport master (
    output controller_clk,
    output controller_latch,
    input  controller_data_B
  );

  modport slave (
    input  controller_clk,
    input  controller_latch,
    output controller_data_B
  );
endinterface

// File: rtl/controller_emulator_m.sv
// controller_emulator_m
// Emulates an 8-button controller shift register on the console connector.
// Host latch/clock are oversampled in the clk domain; the latched snapshot
// is shifted out MSB (button A) first as an active-low serial stream.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   buttons      : active-high button state, bit 7 shifted first
//   turbo_mask   : per-button turbo enable (turbo build only)
//   ctl          : connector pins (slave side of controller_emulator_m_if)
//   frame_strobe : one-cycle pulse per completed latch
//   bit_count    : bits shifted since last latch, saturates at 8
// Optional feature: define CONTROLLER_EMULATOR_TURBO_EN to make turbo-enabled
// buttons read as pressed on alternate latched frames only.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | after reset, waiting for the first latch
// LOAD  | latch high: snapshot reloaded every cycle, count cleared
// SHIFT | shifting one bit per host clock rising edge
// DONE  | all 8 bits sent, data idles high, further clocks ignored
module controller_emulator_m (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              buttons,
  input  logic [7:0]              turbo_mask,
  controller_emulator_m_if.slave  ctl,
  output logic                    frame_strobe,
  output logic [3:0]              bit_count
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  state_t     state, state_nxt;
  logic [2:0] clk_sync, latch_sync;
  logic       clk_rise, latch_high, latch_fall;
  logic [7:0] shreg, shreg_nxt;
  logic [3:0] bit_count_nxt;
  logic       strobe_nxt;
  logic       parity_toggle;
  logic       data_b_q;
  logic [7:0] effective_buttons;

  // [0],[1] synchronize; [2] is the delayed copy for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync   <= 3'b000;
      latch_sync <= 3'b000;
    end else begin
      clk_sync   <= {clk_sync[1:0], ctl.controller_clk};
      latch_sync <= {latch_sync[1:0], ctl.controller_latch};
    end
  end

  assign clk_rise   = clk_sync[1] & ~clk_sync[2];
  assign latch_high = latch_sync[1];
  assign latch_fall = ~latch_sync[1] & latch_sync[2];

`ifdef CONTROLLER_EMULATOR_TURBO_EN
  logic frame_parity;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      frame_parity <= 1'b0;
    else if (parity_toggle)
      frame_parity <= ~frame_parity;
  end

  assign effective_buttons = buttons & ~(turbo_mask & {8{frame_parity}});
`else
  logic unused_turbo;
  assign unused_turbo      = ^{turbo_mask, parity_toggle};
  assign effective_buttons = buttons;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      shreg        <= 8'h00;
      bit_count    <= 4'd0;
      frame_strobe <= 1'b0;
      data_b_q     <= 1'b1;
    end else begin
      state        <= state_nxt;
      shreg        <= shreg_nxt;
      bit_count    <= bit_count_nxt;
      frame_strobe <= strobe_nxt;
      data_b_q     <= ~shreg[7];
    end
  end

  assign ctl.controller_data_B = data_b_q;

  // A high synchronized latch always wins over a host clock edge, so a
  // latch arriving mid-shift aborts the frame and reloads at once.
  always_comb begin
    state_nxt     = state;
    shreg_nxt     = shreg;
    bit_count_nxt = bit_count;
    strobe_nxt    = 1'b0;
    parity_toggle = 1'b0;
    case (state)
      IDLE: begin
        if (latch_high) begin
          state_nxt     = LOAD;
          shreg_nxt     = effective_buttons;
          bit_count_nxt = 4'd0;
        end
      end
      LOAD: begin
        // Loading continues through the falling-edge cycle so the last
        // button value seen while latched is the one shifted out; a clock
        // edge coinciding with the fall is dropped.
        shreg_nxt     = effective_buttons;
        bit_count_nxt = 4'd0;
        if (latch_fall) begin
          state_nxt     = SHIFT;
          strobe_nxt    = 1'b1;
          parity_toggle = 1'b1;
        end
      end
      SHIFT: begin
        if (latch_high) begin
          state_nxt     = LOAD;
          shreg_nxt     = effective_buttons;
          bit_count_nxt = 4'd0;
        end else if (clk_rise) begin
          shreg_nxt     = {shreg[6:0], 1'b0};
          bit_count_nxt = bit_count + 4'd1;
          if (bit_count == 4'd7)
            state_nxt = DONE;
        end
      end
      DONE: begin
        if (latch_high) begin
          state_nxt     = LOAD;
          shreg_nxt     = effective_buttons;
          bit_count_nxt = 4'd0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: doc/controller_emulator_m.md
# controller_emulator_m

Console-side counterpart of the controller serial protocol: emulates a standard 8-button controller shift register so a host console (or our own controller interface in loopback) can latch and clock it. Parallel button state comes from FPGA logic (USB bridge, test pattern, or scripted input); the block answers latch/clock activity on the controller pins with the active-low serial data stream. It sits at the controller connector, fully inside the `clk` domain, and oversamples the host's asynchronous latch and clock.

## Interface
- No parameters.
- `clk` in 1: system clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `buttons` in 8: active-high button state; bit 7 is shifted out first (A), bit 0 last.
- `turbo_mask` in 8: per-button turbo enable; used only with `CONTROLLER_EMULATOR_TURBO_EN`.
- `controller_clk` in 1: host shift clock; asynchronous to `clk`.
- `controller_latch` in 1: host latch; asynchronous to `clk`; active-high.
- `controller_data_B` out 1: serial data; low = pressed.
- `frame_strobe` out 1: one-`clk` pulse on each completed latch (synchronized falling edge).
- `bit_count` out 4: bits shifted since the last latch; saturates at 8.

## Operation
- Two-flop synchronizers on `controller_clk` and `controller_latch`. A third flop on each feeds edge detection: `clk_rise`, `latch_rise`, and `latch_fall`.
- Snapshot register `shreg[7:0]`. `controller_data_B` is a registered copy of `~shreg[7]`.
- States:
  - IDLE: after reset. Goes to LOAD when the synchronized latch is high.
  - LOAD: every `clk` cycle, `shreg <= effective_buttons` and `bit_count <= 0`. Host clock edges are ignored. On `latch_fall`, goes to SHIFT, pulses `frame_strobe`, and toggles `frame_parity`.
  - SHIFT: on `clk_rise`, `shreg <= {shreg[6:0], 1'b0}` and `bit_count` increments. When `bit_count` reaches 8, goes to DONE.
  - DONE: `shreg` is all zeros, so `controller_data_B` stays 1. Further `clk_rise` events are ignored and `bit_count` holds at 8.
- From SHIFT or DONE, a synchronized latch high returns to LOAD immediately. A latch that arrives mid-shift aborts the shift and reloads.
- `effective_buttons = buttons` without turbo (see Configuration).
- Simultaneous `latch_fall` and `clk_rise` in the same cycle: the latch fall is processed and the clock edge is discarded, so bit 7 is still presented.
- A `latch_rise` in the same cycle as `clk_rise` in SHIFT: the load wins and no shift occurs.

## Timing
- Reset values:
  - `controller_data_B` = 1
  - `frame_strobe` = 0
  - `bit_count` = 0
  - `shreg` = 0, `frame_parity` = 0, synchronizer flops = 0
  - state = IDLE
- Reset asserted mid-frame forces all of the above asynchronously. After release, the block waits for the next latch.
- Input-to-output latency: `controller_data_B` reflects a host clock rising edge or a latch change 4 `clk` cycles after the pin transition: 2 sync, 1 edge, 1 output register. The pin transition is registered on the next `clk` edge, so the worst case is within 4–5 edges.
- `frame_strobe` is high for exactly 1 cycle, 3 cycles after the latch pin falls.
- Host requirements:
  - Latch high for ≥ 3 `clk` periods.
  - `controller_clk` high and low phases each ≥ 3 `clk` periods.
  - Host samples data ≥ 5 `clk` periods after its own clock edge.
  - Faster host clocking is unsupported; edges may be lost.

## Configuration
- `CONTROLLER_EMULATOR_TURBO_EN` defined:
  - `effective_buttons = buttons & ~(turbo_mask & {8{frame_parity}})`.
  - Turbo-enabled buttons read as pressed on alternate latched frames only.
  - `frame_parity` toggles on each `latch_fall`.
- Not defined:
  - `turbo_mask` is ignored.
  - `frame_parity` and its logic are removed.
  - `effective_buttons = buttons`.

## Test plan
- Reset, then hold `buttons = 8'hA5` and pulse latch 4 cycles. Clock 8 rising edges at 6-cycle period. Required: `controller_data_B` sequence 0,1,0,1,1,0,1,0; `bit_count` 0→8; one `frame_strobe` pulse.
- After 8 bits, issue 4 more clock edges. Required: `controller_data_B` = 1 and `bit_count` = 8 throughout.
- `buttons = 8'hFF`, latch, 3 clock edges, then re-latch with `buttons = 8'h00`. Required: `bit_count` returns to 0 and `controller_data_B` = 1 with the new snapshot.
- Change `buttons` from `8'h80` to `8'h00` while latch is high, then drop the latch. Required: first bit reads 1 (the last value loaded wins).
- Assert `rst_n` = 0 mid-shift at bit 4. Required: `controller_data_B` = 1 and `bit_count` = 0 immediately; the next full frame is correct.
- TURBO_EN with `turbo_mask = 8'h80` and `buttons = 8'h80`, over 4 frames. Required: first bit reads 0,1,0,1; without the macro, 0,0,0,0.
